ofifo_collect: RTL

//   Output collector at the south edge of the MAC array. Accepts the col-wide psum bus and
//   per-column valid strobes from the last mac_row. Columns arrive skewed, one cycle apart.

---
 rtl/ofifo_collect_pkg.sv | 9 +
 rtl/ofifo_collect_fifo_col.sv | 65 ++++++
 rtl/ofifo_collect.sv | 63 ++++++
 3 files changed

// File: rtl/ofifo_collect_pkg.sv
// Shared array dimensions for the output collector and the MAC rows that feed it.
// Both sides take their defaults from here so the psum bus widths always agree.
package ofifo_collect_pkg;

   localparam int COL         = 8;   // array columns
   localparam int PSUM_BW     = 16;  // bits per partial sum
   localparam int OFIFO_DEPTH = 64;  // entries per column FIFO (power of 2, >= 2)

endpackage

// File: rtl/ofifo_collect_fifo_col.sv
// Single-column first-word-fall-through FIFO.
// dout is always the head entry read straight from storage; it is meaningful
// only while empty=0. A write into a full column is accepted only when a pop
// frees the head slot in the same cycle; otherwise it is dropped and flagged.
module fifo_col
   import ofifo_collect_pkg::*;
#(
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = OFIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [psum_bw-1:0] din,
   input  logic               wr,
   input  logic               pop,
   output logic [psum_bw-1:0] dout,
   output logic               empty,
   output logic               full,
   output logic               drop
);

   localparam int             AW       = $clog2(depth);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(depth);

   logic [psum_bw-1:0] mem [depth];
   logic [AW-1:0]      wptr;
   logic [AW-1:0]      rptr;
   logic [AW:0]        cnt;
   logic               accept;

   assign full   = (cnt == FULL_CNT);
   assign empty  = (cnt == '0);
   assign accept = wr & (~full | pop);
   assign drop   = wr & full & ~pop;
   assign dout   = mem[rptr];

   // Storage: write the incoming psum at the tail when the write is accepted.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         mem[wptr] <= din;
      end
   end

   // Pointers and occupancy: a simultaneous write and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (accept) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/ofifo_collect.sv
// Output collector at the south edge of the MAC array. Each column has its own
// FIFO so the one-cycle-per-column skew of the array is absorbed; a row is
// presented once every column holds at least one entry.
//
// Handshake: o_valid=1 means out carries a complete row. A row is consumed at
// a rising edge where rd=1 and o_valid=1; rd with o_valid=0 has no effect.
// o_valid, o_full and o_ready depend only on registered counts.
module ofifo_collect
   import ofifo_collect_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = OFIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [psum_bw*col-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow
);

   logic [col-1:0] empty;
   logic [col-1:0] full;
   logic [col-1:0] drop;
   logic           pop;

   assign o_valid = &(~empty);
   assign o_full  = |full;
   assign o_ready = ~o_full;
   assign pop     = rd & o_valid;

   for (genvar i = 0; i < col; i++) begin : g_col
      fifo_col #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .din   (in[psum_bw*i +: psum_bw]),
         .wr    (wr[i]),
         .pop   (pop),
         .dout  (out[psum_bw*i +: psum_bw]),
         .empty (empty[i]),
         .full  (full[i]),
         .drop  (drop[i])
      );
   end

   // Sticky overflow: set by any dropped column write, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_overflow <= 1'b0;
      end else if (|drop) begin
         o_overflow <= 1'b1;
      end
   end

endmodule
